// File: rtl/voice_mixer_seq_if.sv
// Bus interface for voice_mixer_seq.
// Groups the mix request (strobe, snapshot inputs, overrun clear) and the mix
// result (sample, valid pulse, clip/busy/overrun flags, FSM state) so that the
// producer side (master) and the mixer (slave) connect through one port.
//   master : drives sample_strobe, signals_in, gains_in, channel_mask,
//            clear_overrun; observes the result signals
//   slave  : the mixer itself, the mirror image of master
// Handshake: sample_strobe is a single-cycle request that is accepted only at
// an edge where busy is low; mixed_valid is a single-cycle pulse that marks
// the cycle in which mixed_signal/clipped carry a fresh result. There is no
// back-pressure; a strobe seen while busy is dropped and flagged in overrun.
interface voice_mixer_seq_if #(
   parameter int N      = 16,
   parameter int W      = 16,
   parameter int GAIN_W = 8,
   parameter int OUT_W  = 20
);
   logic                  sample_strobe;
   logic [N*W-1:0]        signals_in;
   logic [N*GAIN_W-1:0]   gains_in;
   logic [N-1:0]          channel_mask;
   logic                  clear_overrun;
   logic [OUT_W-1:0]      mixed_signal;
   logic                  mixed_valid;
   logic                  clipped;
   logic                  busy;
   logic                  overrun;
   logic [1:0]            state_dbg;

   modport master (
      output sample_strobe, signals_in, gains_in, channel_mask, clear_overrun,
      input  mixed_signal, mixed_valid, clipped, busy, overrun, state_dbg
   );

   modport slave (
      input  sample_strobe, signals_in, gains_in, channel_mask, clear_overrun,
      output mixed_signal, mixed_valid, clipped, busy, overrun, state_dbg
   );
endinterface

// File: rtl/voice_mixer_seq.sv
// Time-multiplexed voice mixer.
// Mixes N unsigned W-bit voices into one OUT_W-bit sample with one
// multiply-accumulate datapath: one channel per clock, per-channel gain
// (g/128, 128 = unity) and enable, saturated registered result.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : voice_mixer_seq_if slave modport (request inputs, result outputs,
//            state_dbg exposes the FSM state)
module voice_mixer_seq #(
   parameter int N      = 16,
   parameter int W      = 16,
   parameter int GAIN_W = 8,
   parameter int OUT_W  = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   voice_mixer_seq_if.slave  bus
);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int PW    = W + GAIN_W;
   localparam int ACC_W = PW + $clog2(N);
   // Working width for the saturation compare: wide enough for both the
   // shifted accumulator and the all-ones output limit.
   localparam int SW    = (ACC_W > OUT_W) ? ACC_W : OUT_W;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

   state_t                state_q, state_d;
   logic [N*W-1:0]        sig_q, sig_d;
   logic [N*GAIN_W-1:0]   gain_q, gain_d;
   logic [N-1:0]          mask_q, mask_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [OUT_W-1:0]      mixed_q, mixed_d;
   logic                  valid_q, valid_d;
   logic                  clip_q, clip_d;
   logic                  overrun_q, overrun_d;

   logic [W-1:0]          cur_sig;
   logic [GAIN_W-1:0]     cur_gain;
   logic [PW-1:0]         prod;
   logic [SW-1:0]         scaled;

   always_comb begin
      cur_sig  = sig_q[int'(idx_q)*W +: W];
      cur_gain = gain_q[int'(idx_q)*GAIN_W +: GAIN_W];
      prod     = PW'(cur_sig) * PW'(cur_gain);
      scaled   = SW'(acc_q) >> 7;
   end

   always_comb begin
      state_d   = state_q;
      sig_d     = sig_q;
      gain_d    = gain_q;
      mask_d    = mask_q;
      acc_d     = acc_q;
      idx_d     = idx_q;
      mixed_d   = mixed_q;
      valid_d   = 1'b0;
      clip_d    = clip_q;
      overrun_d = overrun_q;

      // A strobe while busy is dropped; setting the flag beats a clear.
      if (bus.sample_strobe && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end else if (bus.clear_overrun) begin
         overrun_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (bus.sample_strobe) begin
               sig_d   = bus.signals_in;
               gain_d  = bus.gains_in;
               mask_d  = bus.channel_mask;
               acc_d   = '0;
               idx_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (mask_q[idx_q]) begin
               acc_d = acc_q + ACC_W'(prod);
            end
            if (idx_q == IDX_W'(N - 1)) begin
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (scaled > SW'({OUT_W{1'b1}})) begin
               mixed_d = {OUT_W{1'b1}};
               clip_d  = 1'b1;
            end else begin
               mixed_d = scaled[OUT_W-1:0];
               clip_d  = 1'b0;
            end
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sig_q     <= '0;
         gain_q    <= '0;
         mask_q    <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
         mixed_q   <= '0;
         valid_q   <= 1'b0;
         clip_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sig_q     <= sig_d;
         gain_q    <= gain_d;
         mask_q    <= mask_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
         mixed_q   <= mixed_d;
         valid_q   <= valid_d;
         clip_q    <= clip_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.mixed_signal = mixed_q;
   assign bus.mixed_valid  = valid_q;
   assign bus.clipped      = clip_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.overrun      = overrun_q;
   assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_voice_mixer_seq.sv
// Directed bench for voice_mixer_seq: a default-parameter instance plus a
// small N=4/W=8/OUT_W=10 instance, both on the same clock and reset.
module tb_voice_mixer_seq;
   logic clk;
   logic rst_n;
   int   vec_cnt;
   int   miss_cnt;

   voice_mixer_seq_if #(.N(16), .W(16), .GAIN_W(8), .OUT_W(20)) bus16 ();
   voice_mixer_seq_if #(.N(4),  .W(8),  .GAIN_W(8), .OUT_W(10)) bus4 ();

   voice_mixer_seq #(.N(16), .W(16), .GAIN_W(8), .OUT_W(20)) dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus16)
   );

   voice_mixer_seq #(.N(4), .W(8), .GAIN_W(8), .OUT_W(10)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic set_all16(input logic [15:0] s, input logic [7:0] g, input logic [15:0] m);
      bus16.signals_in   = {16{s}};
      bus16.gains_in     = {16{g}};
      bus16.channel_mask = m;
   endtask

   // Strobe for one cycle, then watch 30 edges. edges = edge count (from the
   // strobe edge) of the first valid, or 0 when no valid occurs.
   task automatic run_pass16(output int edges, output int nvalid,
                             output logic [19:0] res, output logic clip,
                             output logic busy_start);
      edges  = 0;
      nvalid = 0;
      res    = '0;
      clip   = 1'b0;
      @(negedge clk);
      bus16.sample_strobe = 1'b1;
      @(negedge clk);
      bus16.sample_strobe = 1'b0;
      busy_start = bus16.busy;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (bus16.mixed_valid) begin
            nvalid++;
            if (edges == 0) begin
               edges = k;
               res   = bus16.mixed_signal;
               clip  = bus16.clipped;
            end
         end
      end
   endtask

   task automatic run_pass4(output int edges, output logic [9:0] res, output logic clip);
      edges = 0;
      res   = '0;
      clip  = 1'b0;
      @(negedge clk);
      bus4.sample_strobe = 1'b1;
      @(negedge clk);
      bus4.sample_strobe = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (bus4.mixed_valid && edges == 0) begin
            edges = k;
            res   = bus4.mixed_signal;
            clip  = bus4.clipped;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      vec_cnt++;
      if (bus16.mixed_signal !== 20'd0 || bus16.mixed_valid !== 1'b0 || bus16.clipped !== 1'b0 ||
          bus16.busy !== 1'b0 || bus16.overrun !== 1'b0) begin
         miss_cnt++;
         $display("FAIL reset: sig=%0d valid=%b clip=%b busy=%b ovr=%b, want all 0",
                  bus16.mixed_signal, bus16.mixed_valid, bus16.clipped, bus16.busy, bus16.overrun);
      end
   endtask

   task automatic test_unity;
      int e, nv;
      logic [19:0] r;
      logic c, b;
      set_all16(16'd1000, 8'd128, 16'hFFFF);
      run_pass16(e, nv, r, c, b);
      vec_cnt++;
      if (e !== 17) begin miss_cnt++; $display("FAIL unity_latency: got %0d edges, want 17", e); end
      vec_cnt++;
      if (r !== 20'd16000 || c !== 1'b0) begin
         miss_cnt++; $display("FAIL unity_value: got %0d clip=%b, want 16000 clip=0", r, c);
      end
      vec_cnt++;
      if (b !== 1'b1) begin miss_cnt++; $display("FAIL unity_busy: got %b, want 1", b); end
      vec_cnt++;
      if (nv !== 1) begin miss_cnt++; $display("FAIL unity_pulses: got %0d, want 1", nv); end
      vec_cnt++;
      if (bus16.mixed_signal !== 20'd16000 || bus16.mixed_valid !== 1'b0 || bus16.busy !== 1'b0) begin
         miss_cnt++;
         $display("FAIL unity_hold: sig=%0d valid=%b busy=%b, want 16000 0 0",
                  bus16.mixed_signal, bus16.mixed_valid, bus16.busy);
      end
   endtask

   task automatic test_saturate;
      int e, nv;
      logic [19:0] r;
      logic c, b;
      set_all16(16'hFFFF, 8'd255, 16'hFFFF);
      run_pass16(e, nv, r, c, b);
      vec_cnt++;
      if (r !== 20'd1048575 || c !== 1'b1) begin
         miss_cnt++; $display("FAIL saturate: got %0d clip=%b, want 1048575 clip=1", r, c);
      end
      set_all16(16'd0, 8'd255, 16'hFFFF);
      run_pass16(e, nv, r, c, b);
      vec_cnt++;
      if (r !== 20'd0 || c !== 1'b0 || e !== 17) begin
         miss_cnt++; $display("FAIL zero_after_sat: got %0d clip=%b edges=%0d, want 0 0 17", r, c, e);
      end
   endtask

   task automatic test_mask_trunc;
      int e, nv;
      logic [19:0] r;
      logic c, b;
      set_all16(16'hFFFF, 8'd255, 16'h0008);
      bus16.signals_in[3*16 +: 16] = 16'd40000;
      bus16.gains_in[3*8 +: 8]     = 8'd64;
      run_pass16(e, nv, r, c, b);
      vec_cnt++;
      if (r !== 20'd20000 || c !== 1'b0) begin
         miss_cnt++; $display("FAIL mask_single: got %0d clip=%b, want 20000 clip=0", r, c);
      end
      bus16.signals_in[15:0] = 16'd3;
      bus16.gains_in[7:0]    = 8'd1;
      bus16.channel_mask     = 16'h0001;
      run_pass16(e, nv, r, c, b);
      vec_cnt++;
      if (r !== 20'd0 || nv !== 1) begin
         miss_cnt++; $display("FAIL truncate: got %0d pulses=%0d, want 0 pulses=1", r, nv);
      end
      set_all16(16'hFFFF, 8'd255, 16'h0000);
      run_pass16(e, nv, r, c, b);
      vec_cnt++;
      if (r !== 20'd0 || c !== 1'b0 || nv !== 1) begin
         miss_cnt++; $display("FAIL empty_mask: got %0d clip=%b pulses=%0d, want 0 0 1", r, c, nv);
      end
      // Gain 0 on an enabled channel contributes nothing.
      set_all16(16'd1000, 8'd128, 16'hFFFF);
      bus16.gains_in[5*8 +: 8] = 8'd0;
      run_pass16(e, nv, r, c, b);
      vec_cnt++;
      if (r !== 20'd15000) begin miss_cnt++; $display("FAIL gain_zero: got %0d, want 15000", r); end
   endtask

   task automatic test_overrun;
      int e, nv;
      logic [19:0] r;
      for (int i = 0; i < 16; i++) bus16.signals_in[i*16 +: 16] = 16'(i * 100);
      bus16.gains_in     = {16{8'd128}};
      bus16.channel_mask = 16'hFFFF;
      e = 0; nv = 0; r = '0;
      @(negedge clk);
      bus16.sample_strobe = 1'b1;
      @(negedge clk);
      bus16.sample_strobe = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1) begin
            for (int i = 0; i < 16; i++) bus16.signals_in[i*16 +: 16] = 16'($urandom_range(0, 65535));
         end
         bus16.sample_strobe = (k == 4);
         if (bus16.mixed_valid) begin
            nv++;
            if (e == 0) begin e = k; r = bus16.mixed_signal; end
         end
      end
      vec_cnt++;
      if (r !== 20'd12000 || e !== 17) begin
         miss_cnt++; $display("FAIL snapshot: got %0d at edge %0d, want 12000 at 17", r, e);
      end
      vec_cnt++;
      if (nv !== 1) begin miss_cnt++; $display("FAIL busy_strobe_pulses: got %0d, want 1", nv); end
      vec_cnt++;
      if (bus16.overrun !== 1'b1) begin miss_cnt++; $display("FAIL overrun_set: got %b, want 1", bus16.overrun); end
      @(negedge clk);
      bus16.clear_overrun = 1'b1;
      @(negedge clk);
      bus16.clear_overrun = 1'b0;
      vec_cnt++;
      if (bus16.overrun !== 1'b0) begin miss_cnt++; $display("FAIL overrun_clear: got %b, want 0", bus16.overrun); end
      // Busy strobe and clear in the same cycle: the set must win.
      @(negedge clk);
      bus16.sample_strobe = 1'b1;
      @(negedge clk);
      bus16.sample_strobe = 1'b0;
      repeat (3) @(negedge clk);
      bus16.sample_strobe = 1'b1;
      bus16.clear_overrun = 1'b1;
      @(negedge clk);
      bus16.sample_strobe = 1'b0;
      bus16.clear_overrun = 1'b0;
      vec_cnt++;
      if (bus16.overrun !== 1'b1) begin miss_cnt++; $display("FAIL overrun_set_wins: got %b, want 1", bus16.overrun); end
      repeat (20) @(negedge clk);
      bus16.clear_overrun = 1'b1;
      @(negedge clk);
      bus16.clear_overrun = 1'b0;
   endtask

   task automatic test_back_to_back;
      int e, w;
      logic [19:0] r;
      set_all16(16'd1000, 8'd128, 16'hFFFF);
      @(negedge clk);
      bus16.sample_strobe = 1'b1;
      @(negedge clk);
      bus16.sample_strobe = 1'b0;
      w = 0;
      while (!bus16.mixed_valid && w < 40) begin @(negedge clk); w++; end
      vec_cnt++;
      if (bus16.mixed_valid !== 1'b1 || bus16.mixed_signal !== 20'd16000) begin
         miss_cnt++;
         $display("FAIL b2b_first: valid=%b sig=%0d, want 1 16000", bus16.mixed_valid, bus16.mixed_signal);
      end
      // Strobe during the valid cycle: FSM is IDLE at that edge.
      set_all16(16'd2000, 8'd128, 16'hFFFF);
      bus16.sample_strobe = 1'b1;
      @(negedge clk);
      bus16.sample_strobe = 1'b0;
      e = 0; r = '0;
      for (int k = 1; k <= 30 && e == 0; k++) begin
         @(negedge clk);
         if (bus16.mixed_valid) begin e = k; r = bus16.mixed_signal; end
      end
      vec_cnt++;
      if (e !== 17 || r !== 20'd32000) begin
         miss_cnt++; $display("FAIL b2b_second: got %0d at edge %0d, want 32000 at 17", r, e);
      end
      vec_cnt++;
      if (bus16.overrun !== 1'b0) begin miss_cnt++; $display("FAIL b2b_no_overrun: got %b, want 0", bus16.overrun); end
   endtask

   task automatic test_async_reset;
      int e, nv, seen;
      logic [19:0] r;
      logic c, b;
      set_all16(16'd1000, 8'd128, 16'hFFFF);
      @(negedge clk);
      bus16.sample_strobe = 1'b1;
      @(negedge clk);
      bus16.sample_strobe = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (bus16.mixed_signal !== 20'd0 || bus16.mixed_valid !== 1'b0 || bus16.clipped !== 1'b0 ||
          bus16.busy !== 1'b0 || bus16.overrun !== 1'b0) begin
         miss_cnt++;
         $display("FAIL async_reset: sig=%0d valid=%b clip=%b busy=%b ovr=%b, want all 0",
                  bus16.mixed_signal, bus16.mixed_valid, bus16.clipped, bus16.busy, bus16.overrun);
      end
      seen = 0;
      repeat (3) begin @(negedge clk); if (bus16.mixed_valid) seen++; end
      rst_n = 1'b1;
      repeat (20) begin @(negedge clk); if (bus16.mixed_valid) seen++; end
      vec_cnt++;
      if (seen !== 0) begin miss_cnt++; $display("FAIL aborted_no_valid: got %0d pulses, want 0", seen); end
      run_pass16(e, nv, r, c, b);
      vec_cnt++;
      if (r !== 20'd16000 || e !== 17) begin
         miss_cnt++; $display("FAIL after_reset: got %0d at edge %0d, want 16000 at 17", r, e);
      end
   endtask

   task automatic test_small_params;
      int e;
      logic [9:0] r;
      logic c;
      bus4.signals_in   = {4{8'd255}};
      bus4.gains_in     = {4{8'd255}};
      bus4.channel_mask = 4'hF;
      run_pass4(e, r, c);
      vec_cnt++;
      if (e !== 5 || r !== 10'd1023 || c !== 1'b1) begin
         miss_cnt++; $display("FAIL small_sat: got %0d clip=%b edge=%0d, want 1023 1 5", r, c, e);
      end
      bus4.signals_in   = {4{8'd100}};
      bus4.gains_in     = {4{8'd128}};
      bus4.channel_mask = 4'b0101;
      run_pass4(e, r, c);
      vec_cnt++;
      if (e !== 5 || r !== 10'd200 || c !== 1'b0) begin
         miss_cnt++; $display("FAIL small_mask: got %0d clip=%b edge=%0d, want 200 0 5", r, c, e);
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      vec_cnt  = 0;
      miss_cnt = 0;
      rst_n    = 1'b0;
      bus16.sample_strobe = 1'b0;
      bus16.clear_overrun = 1'b0;
      set_all16(16'd0, 8'd0, 16'h0000);
      bus4.sample_strobe  = 1'b0;
      bus4.clear_overrun  = 1'b0;
      bus4.signals_in     = '0;
      bus4.gains_in       = '0;
      bus4.channel_mask   = '0;
      repeat (3) @(negedge clk);
      test_reset;
      rst_n = 1'b1;
      @(negedge clk);
      test_unity;
      test_saturate;
      test_mask_trunc;
      test_overrun;
      test_back_to_back;
      test_async_reset;
      test_small_params;
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end
endmodule

// File: doc/voice_mixer_seq.md
Name: voice_mixer_seq

Overview:
Parametrised, time-multiplexed successor to the fixed 16-input adder-tree mixer. It mixes N unsigned W-bit oscillator/voice signals into one OUT_W-bit sample using a single multiply-accumulate datapath. Each channel has its own gain and enable. The block sits between the voice oscillators and the output DAC/codec stage. Mixing runs once per sample_strobe and ends with a registered, saturated result plus a one-cycle valid pulse.

Parameters:
N, 16, number of input channels (>=2)
W, 16, width of each unsigned input signal
GAIN_W, 8, width of each unsigned per-channel gain; gain g scales by g/128 (128 = unity)
OUT_W, 20, width of mixed output; result saturates to 2^OUT_W-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sample_strobe  input  1  start one mix pass; sampled only while idle
signals_in  input  N*W  channel i at [i*W +: W], unsigned
gains_in  input  N*GAIN_W  channel i gain at [i*GAIN_W +: GAIN_W]
channel_mask  input  N  bit i=1 includes channel i
clear_overrun  input  1  synchronous clear of overrun flag
mixed_signal  output  OUT_W  registered mixed sample, held between passes
mixed_valid  output  1  one-cycle pulse when mixed_signal updates
clipped  output  1  registered with mixed_signal: 1 if last result saturated
busy  output  1  high while a pass is in progress (state != IDLE)
overrun  output  1  sticky: strobe arrived while busy

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (asserts at any time, including mid-pass): mixed_signal=0, mixed_valid=0, clipped=0, busy=0, overrun=0, accumulator=0, index=0, state=IDLE. An aborted pass produces no mixed_valid.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: on sample_strobe=1 at edge E0, snapshot signals_in, gains_in and channel_mask into internal registers. Clear the accumulator, set index=0, go to ACCUM. Input changes after E0 do not affect the pass.
- ACCUM: one channel per edge, E1..EN. Update acc += mask[idx] ? sig[idx]*gain[idx] : 0, then idx++. After the idx=N-1 update, go to DONE.
- Accumulator width is W+GAIN_W+ceil(log2 N), so it never overflows (28 bits at defaults). The product is exact, W+GAIN_W bits.
- DONE at edge EN+1:
  - s = acc >> 7 (floor, truncation).
  - If s > 2^OUT_W-1: mixed_signal = 2^OUT_W-1 and clipped=1.
  - Otherwise mixed_signal = s and clipped=0.
  - mixed_valid=1 for exactly one cycle. Go to IDLE.
- Latency: mixed_valid is high in the cycle after edge E0+N+1. busy is high from after E0 through the DONE cycle.
- Minimum strobe spacing is N+2 cycles. A strobe in the same cycle mixed_valid is high is accepted, because the FSM is in IDLE at that edge.
- Strobe while busy (ACCUM or DONE): ignored and the current pass is unaffected. overrun is set to 1 and held.
- clear_overrun=1 clears overrun at the next edge. If clear_overrun and a busy-strobe occur in the same cycle, set wins.
- Gain 0 or mask bit 0 means the channel contributes exactly 0. A mask of all zeros gives mixed_signal=0, clipped=0, with a normal valid pulse.
- mixed_signal and clipped change only in DONE or on reset.

Test Plan:
- Defaults, all 16 signals=1000, gains=128, mask=16'hFFFF, strobe one cycle -> mixed_valid exactly 17 edges after the strobe edge, mixed_signal=16000, clipped=0, busy high during the pass.
- All signals=65535, gains=255, full mask -> mixed_signal=1048575, clipped=1. Next pass with all signals=0 -> mixed_signal=0, clipped=0.
- Mask=16'h0008, signal3=40000, gain3=64, other channels at max values -> mixed_signal=20000. Then signal0=3, gain0=1, mask=1 -> mixed_signal=0 (truncation).
- Strobe, then change signals_in to random values and strobe again 5 cycles later -> result matches the first snapshot, only one mixed_valid, overrun=1. clear_overrun pulse -> overrun=0. Strobe in the valid cycle -> accepted, second valid 17 edges later.
- Assert rst_n=0 at the 8th ACCUM cycle -> all outputs 0 immediately (asynchronous), no mixed_valid. Release and strobe with all signals=1000, gains=128 -> mixed_signal=16000.
- Parameter set N=4, W=8, GAIN_W=8, OUT_W=10, signals=255, gains=255, full mask -> mixed_valid 5 edges after strobe, mixed_signal=1023, clipped=1.
